booth_div: RTL and testbench

//   Sequential signed two's-complement divider; inverse of the booth_mult datapath.

---
 rtl/booth_div.sv | 125 ++++++++++++
 tb/tb_booth_div.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/booth_div.sv
// Sequential signed divider: restoring division on operand magnitudes, one quotient
// bit per clock, followed by a sign fix-up cycle. Companion to booth_mult.
module booth_div #(
   parameter int width = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [width-1:0] A,
   input  logic [width-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [width-1:0] Q,
   output logic [width-1:0] R,
   output logic             div_zero,
   output logic             ovf
);

   localparam int CW = $clog2(width + 1);
   localparam logic [width-1:0] MOST_NEG = {1'b1, {(width-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t state_reg, state_next;

   logic             sign_a_reg, sign_b_reg;
   logic [width-1:0] mag_b_reg;
   logic [width:0]   rem_reg;
   logic [width-1:0] quo_reg;
   logic [CW-1:0]    cnt_reg;
   logic             zero_reg, ovf_pend_reg;
   logic             busy_reg, done_reg, div_zero_reg, ovf_reg;
   logic [width-1:0] q_reg, r_reg;

   logic [width-1:0] abs_a, abs_b;
   logic [width+1:0] rem_sh, trial;
   logic             trial_ok;

   assign abs_a = A[width-1] ? -A : A;
   assign abs_b = B[width-1] ? -B : B;

   // One extra headroom bit so the trial subtraction's sign bit is a clean borrow.
   assign rem_sh   = {rem_reg, quo_reg[width-1]};
   assign trial    = rem_sh - {2'b00, mag_b_reg};
   assign trial_ok = ~trial[width+1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (start) state_next = (B == '0) ? FIX : CALC;
         CALC: if (cnt_reg == CW'(1)) state_next = FIX;
         FIX:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sign_a_reg   <= 1'b0;
         sign_b_reg   <= 1'b0;
         mag_b_reg    <= '0;
         rem_reg      <= '0;
         quo_reg      <= '0;
         cnt_reg      <= '0;
         zero_reg     <= 1'b0;
         ovf_pend_reg <= 1'b0;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
         div_zero_reg <= 1'b0;
         ovf_reg      <= 1'b0;
         q_reg        <= '0;
         r_reg        <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               done_reg <= 1'b0;
               if (start) begin
                  sign_a_reg   <= A[width-1];
                  sign_b_reg   <= B[width-1];
                  quo_reg      <= abs_a;
                  mag_b_reg    <= abs_b;
                  rem_reg      <= '0;
                  cnt_reg      <= CW'(width);
                  zero_reg     <= (B == '0);
                  ovf_pend_reg <= (A == MOST_NEG) && (B == '1);
                  busy_reg     <= 1'b1;
               end
            end
            CALC: begin
               rem_reg <= trial_ok ? trial[width:0] : rem_sh[width:0];
               quo_reg <= {quo_reg[width-2:0], trial_ok};
               cnt_reg <= cnt_reg - CW'(1);
            end
            FIX: begin
               // On divide-by-zero quo still holds |A|, so re-signing it restores A.
               if (zero_reg) begin
                  q_reg <= '1;
                  r_reg <= sign_a_reg ? -quo_reg : quo_reg;
               end else begin
                  q_reg <= (sign_a_reg ^ sign_b_reg) ? -quo_reg : quo_reg;
                  r_reg <= sign_a_reg ? -rem_reg[width-1:0] : rem_reg[width-1:0];
               end
               div_zero_reg <= zero_reg;
               ovf_reg      <= ovf_pend_reg;
               done_reg     <= 1'b1;
               busy_reg     <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign busy     = busy_reg;
   assign done     = done_reg;
   assign Q        = q_reg;
   assign R        = r_reg;
   assign div_zero = div_zero_reg;
   assign ovf      = ovf_reg;

endmodule

// File: tb/tb_booth_div.sv
// Scoreboard bench for booth_div: the driver pushes model results with their
// expected timing, and a negedge monitor checks busy/done and results each cycle.
module tb_booth_div;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] A = '0;
   logic [W-1:0] B = '0;
   logic         busy, done, div_zero, ovf;
   logic [W-1:0] Q, R;

   booth_div #(.width(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
      .busy(busy), .done(done), .Q(Q), .R(R), .div_zero(div_zero), .ovf(ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      int           acc;
      int           done_edge;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dz;
      logic         ov;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h required %0h", name, cyc, act, exp);
      end
   endtask

   // C-style truncating division with the divider's special cases.
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      int   ai, bi;
      ai = int'($signed(a));
      bi = int'($signed(b));
      e.a = a; e.b = b; e.dz = 1'b0; e.ov = 1'b0; e.acc = 0; e.done_edge = 0;
      if (bi == 0) begin
         e.q = '1; e.r = a; e.dz = 1'b1;
      end else if (ai == -(2 ** (W - 1)) && bi == -1) begin
         e.q = {1'b1, {(W-1){1'b0}}}; e.r = '0; e.ov = 1'b1;
      end else begin
         e.q = W'(ai / bi);
         e.r = W'(ai % bi);
      end
      return e;
   endfunction

   always @(negedge clk) begin
      bit have, busy_e, done_e;
      have   = sb.size() > 0;
      busy_e = have && sb[0].acc <= cyc && cyc < sb[0].done_edge;
      done_e = have && cyc == sb[0].done_edge;
      check("busy", 32'(busy), 32'(busy_e));
      check("done", 32'(done), 32'(done_e));
      if (done_e) begin
         check("Q", 32'(Q), 32'(sb[0].q));
         check("R", 32'(R), 32'(sb[0].r));
         check("div_zero", 32'(div_zero), 32'(sb[0].dz));
         check("ovf", 32'(ovf), 32'(sb[0].ov));
         $display("op A=%02h B=%02h -> Q=%02h R=%02h dz=%0b ovf=%0b (exp Q=%02h R=%02h)",
                  sb[0].a, sb[0].b, Q, R, div_zero, ovf, sb[0].q, sb[0].r);
         void'(sb.pop_front());
      end
   end

   // Called at a negedge; returns at the negedge of the done cycle so the next
   // call is accepted back-to-back. Noise keeps start high with junk operands.
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input bit noise);
      exp_t e;
      int   lat;
      lat = (b == '0) ? 1 : W + 1;
      e = model(a, b);
      e.acc = cyc + 1;
      e.done_edge = cyc + 1 + lat;
      sb.push_back(e);
      A = a; B = b; start = 1'b1;
      @(posedge clk);
      for (int k = 0; k < lat; k++) begin
         @(negedge clk);
         start = noise;
         if (noise) begin
            A = W'($urandom);
            B = W'($urandom);
         end
         @(posedge clk);
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      exp_t         e;
      logic [W-1:0] ra, rb;
      int           gap;

      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_Q", 32'(Q), 32'd0);
      check("rst_R", 32'(R), 32'd0);
      check("rst_div_zero", 32'(div_zero), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      send(8'd100, 8'd7, 1'b0);
      send(8'h9C, 8'd7, 1'b0);
      send(8'd100, 8'hF9, 1'b0);
      send(8'h9C, 8'hF9, 1'b0);
      send(8'h80, 8'hFF, 1'b0);
      send(8'h80, 8'h01, 1'b0);
      send(8'd5, 8'd0, 1'b0);
      send(8'd6, 8'd3, 1'b0);
      send(8'd100, 8'd7, 1'b1);

      // Abort: reset four edges after acceptance must clear everything at once.
      e = model(8'd77, 8'd5);
      e.acc = cyc + 1;
      e.done_edge = cyc + 1 + W + 1;
      sb.push_back(e);
      A = 8'd77; B = 8'd5; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst_n = 1'b0;
      sb.delete();
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_Q", 32'(Q), 32'd0);
      check("abort_R", 32'(R), 32'd0);
      check("abort_flags", 32'({div_zero, ovf}), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);

      for (int n = 0; n < 300; n++) begin
         gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
         repeat (gap) @(negedge clk);
         ra = W'($urandom);
         rb = W'($urandom);
         case ($urandom_range(0, 9))
            0: ra = 8'h80;
            1: rb = 8'hFF;
            2: begin ra = 8'h80; rb = 8'hFF; end
            3: rb = W'($urandom_range(1, 3));
            default: ;
         endcase
         if (rb == '0) rb = 8'd1;
         send(ra, rb, $urandom_range(0, 3) == 0);
      end

      repeat (4) @(negedge clk);
      check("drain", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
